// File: rtl/hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_if
// Description : Control-path bundle between the pipeline and hazard_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic             use_rs1_id;
    logic             use_rs2_id;
    logic [4:0]       rd_idex;
    logic             mem_read_idex;
    logic             branch_taken_ex;
    logic             dmem_req;
    logic             dmem_ready;
    logic             stall_front;
    logic             bubble_idex;
    logic             flush_front;
    logic             hold_back;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_idex,
               mem_read_idex, branch_taken_ex, dmem_req, dmem_ready,
        input  stall_front, bubble_idex, flush_front, hold_back,
               mem_timeout, stall_count, flush_count
    );

    modport slave (
        input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_idex,
               mem_read_idex, branch_taken_ex, dmem_req, dmem_ready,
        output stall_front, bubble_idex, flush_front, hold_back,
               mem_timeout, stall_count, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Load-use bubble, memory-wait hold and branch flush control.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    hazard_unit_if.slave  hu
);
    localparam int c_TO_W   = $clog2(MEM_TIMEOUT + 1);
    localparam int c_WCNT_W = (c_TO_W > 8) ? c_TO_W : 8;

    localparam logic [0:0]          c_ST_RUN    = 1'b0;
    localparam logic [0:0]          c_ST_WAIT   = 1'b1;
    localparam logic [c_WCNT_W-1:0] c_WCNT_MAX  = '1;
    localparam logic [c_WCNT_W-1:0] c_WCNT_ONE  = c_WCNT_W'(1);
    localparam logic [c_WCNT_W-1:0] c_TIMEOUT   = c_WCNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);

    logic                w_load_use;
    logic                w_mem_wait;
    logic                w_stall;
    logic                w_flush;
    logic                w_bubble;
    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_WCNT_W-1:0] r_wait_cnt;
    logic [c_WCNT_W-1:0] w_wait_cnt_nxt;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_stall_count;
    logic [CNT_W-1:0]    r_flush_count;

    assign w_load_use = hu.mem_read_idex && (hu.rd_idex != 5'd0) &&
                        ((hu.use_rs1_id && (hu.rs1_id == hu.rd_idex)) ||
                         (hu.use_rs2_id && (hu.rs2_id == hu.rd_idex)));
    assign w_mem_wait = hu.dmem_req && !hu.dmem_ready;

    // Priority: memory hold, then branch flush, then load-use bubble.
    assign w_stall  = w_mem_wait || (w_load_use && !hu.branch_taken_ex);
    assign w_flush  = hu.branch_taken_ex && !w_mem_wait;
    assign w_bubble = w_load_use && !hu.branch_taken_ex && !w_mem_wait;

    assign hu.hold_back   = reset_n && w_mem_wait;
    assign hu.stall_front = reset_n && w_stall;
    assign hu.flush_front = reset_n && w_flush;
    assign hu.bubble_idex = reset_n && w_bubble;
    assign hu.mem_timeout = r_timeout;
    assign hu.stall_count = r_stall_count;
    assign hu.flush_count = r_flush_count;

    // wait_cnt holds the number of consecutive wait cycles already elapsed,
    // counting the RUN cycle that entered WAIT.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = '0;
        case (r_state)
            c_ST_RUN: begin
                if (w_mem_wait) begin
                    w_state_nxt    = c_ST_WAIT;
                    w_wait_cnt_nxt = c_WCNT_ONE;
                end
            end
            c_ST_WAIT: begin
                if (w_mem_wait) begin
                    w_wait_cnt_nxt = (r_wait_cnt == c_WCNT_MAX) ? r_wait_cnt
                                                                : r_wait_cnt + c_WCNT_ONE;
                end else begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_ST_RUN;
            r_wait_cnt    <= '0;
            r_timeout     <= 1'b0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_mem_wait && (r_wait_cnt == c_TIMEOUT)) begin
                r_timeout <= 1'b1;
            end
            if (w_stall && (r_stall_count != c_CNT_MAX)) begin
                r_stall_count <= r_stall_count + c_CNT_ONE;
            end
            if (w_flush && (r_flush_count != c_CNT_MAX)) begin
                r_flush_count <= r_flush_count + c_CNT_ONE;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Scoreboard bench for hazard_unit with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;
    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int CMAX        = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             stall;
        logic             bubble;
        logic             flush;
        logic             hold;
        logic             tmo;
        logic [CNT_W-1:0] scnt;
        logic [CNT_W-1:0] fcnt;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_unit #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hu      (bus)
    );

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_a;
    int   errors = 0;
    int   checks = 0;

    // Model state: saturating event totals and the length of the current
    // run of consecutive memory-wait cycles.
    int   m_scnt = 0;
    int   m_fcnt = 0;
    int   m_run  = 0;
    bit   m_tmo  = 1'b0;

    task automatic apply(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2, input logic [4:0] rd,
                         input bit mr, input bit br, input bit req, input bit rdy);
        exp_t e;
        bit   lu;
        bit   mw;
        @(posedge clk);
        #1;
        reset_n             = rst;
        bus.rs1_id          = rs1;
        bus.rs2_id          = rs2;
        bus.use_rs1_id      = u1;
        bus.use_rs2_id      = u2;
        bus.rd_idex         = rd;
        bus.mem_read_idex   = mr;
        bus.branch_taken_ex = br;
        bus.dmem_req        = req;
        bus.dmem_ready      = rdy;
        lu = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        mw = req && !rdy;
        e  = '0;
        if (!rst) begin
            m_scnt = 0;
            m_fcnt = 0;
            m_run  = 0;
            m_tmo  = 1'b0;
        end else begin
            e.hold   = mw;
            e.stall  = mw || (lu && !br);
            e.flush  = br && !mw;
            e.bubble = lu && !br && !mw;
            e.tmo    = m_tmo;
            e.scnt   = CNT_W'(m_scnt);
            e.fcnt   = CNT_W'(m_fcnt);
            if (e.stall && m_scnt < CMAX) m_scnt++;
            if (e.flush && m_fcnt < CMAX) m_fcnt++;
            m_run = mw ? m_run + 1 : 0;
            if (mw && m_run == MEM_TIMEOUT + 1) m_tmo = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit rst);
        apply(rst, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = {bus.stall_front, bus.bubble_idex, bus.flush_front, bus.hold_back,
                         bus.mem_timeout, bus.stall_count, bus.flush_count};
                checks++;
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL outputs t=%0t actual{stall,bubble,flush,hold,tmo,scnt,fcnt}=%b,%b,%b,%b,%b,%0d,%0d required=%b,%b,%b,%b,%b,%0d,%0d",
                             $time, mon_a.stall, mon_a.bubble, mon_a.flush, mon_a.hold, mon_a.tmo,
                             mon_a.scnt, mon_a.fcnt, mon_e.stall, mon_e.bubble, mon_e.flush,
                             mon_e.hold, mon_e.tmo, mon_e.scnt, mon_e.fcnt);
                end
            end
        end
    end

    initial begin
        idle(1'b0);
        idle(1'b0);
        // Load x5 in EX, ID reads rs1=5; then the load moves on.
        apply(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        // No hazard: rd=x0 load, and unused rs2 matching.
        apply(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        // Branch with a load-use hazard: flush only.
        apply(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        // Three-cycle wait with branch held, then the release cycle flushes.
        repeat (3) apply(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        apply(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        // Ten-cycle wait trips the timeout, which then stays set until reset.
        repeat (10) apply(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) idle(1'b1);
        idle(1'b0);
        idle(1'b1);
        // Twenty load-use stalls saturate the 4-bit counter.
        repeat (20) apply(1'b1, 5'd3, 5'd4, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        // Reset asserted in the middle of a wait with a hazard present.
        repeat (3) apply(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        apply(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        // Randomized traffic biased towards register-number collisions.
        for (int i = 0; i < 600; i++) begin
            apply(($urandom_range(0, 39) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 4) < 2), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d pending required=0 pending", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage core: the stall/flush counterpart to the operand-forwarding logic. Forwarding covers every RAW case except a load feeding the next instruction; this block covers that case with a one-cycle bubble. It also freezes the pipeline while a data-memory access is outstanding and flushes the front end on a taken branch. It sits beside the forwarding unit in the control path and drives the PC, IF/ID, ID/EX and back-end pipeline-register enables.

## Interface
Parameters:
- CNT_W, 32: width of the saturating performance counters.
- MEM_TIMEOUT, 255: number of consecutive wait cycles after which mem_timeout sets.

Ports:
- clk  in  1  core clock; every register updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rs1_id, rs2_id  in  5 each  source registers of the instruction in ID.
- use_rs1_id, use_rs2_id  in  1 each  the ID instruction actually reads rs1 / rs2.
- rd_idex  in  5  destination register of the instruction in EX.
- mem_read_idex  in  1  the instruction in EX is a load.
- branch_taken_ex  in  1  the branch/jump in EX redirects the PC.
- dmem_req  in  1  the MEM stage is issuing a data-memory access.
- dmem_ready  in  1  the data memory completes the access this cycle.
- stall_front  out  1  hold PC and IF/ID: both write enables are low.
- bubble_idex  out  1  load a NOP (all control zero) into ID/EX.
- flush_front  out  1  clear IF/ID and ID/EX to NOP.
- hold_back  out  1  hold ID/EX, EX/MEM and MEM/WB.
- mem_timeout  out  1  sticky error flag: the memory wait exceeded MEM_TIMEOUT.
- stall_count  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of flush events.

## Operation
- Combinational terms:
  - load_use = mem_read_idex & rd_idex≠0 & ((use_rs1_id & rs1_id==rd_idex) | (use_rs2_id & rs2_id==rd_idex)).
  - mem_wait = dmem_req & !dmem_ready.
- Output priority is mem_wait, then flush, then load-use:
  - hold_back = mem_wait.
  - stall_front = mem_wait | (load_use & !branch_taken_ex).
  - flush_front = branch_taken_ex & !mem_wait.
  - bubble_idex = load_use & !branch_taken_ex & !mem_wait.
- A taken branch kills the ID instruction, so it suppresses the load-use stall.
- During a hold, EX is frozen and branch_taken_ex stays asserted. The flush therefore fires in the release cycle, when dmem_ready=1.
- State machine, two states, reset to RUN:
  - RUN→WAIT when mem_wait=1.
  - WAIT→RUN when dmem_ready=1, or when dmem_req drops (aborted access).
  - Each of those cycles is registered.
- wait_cnt (8 bits minimum, wide enough for MEM_TIMEOUT):
  - clears in RUN.
  - increments each WAIT cycle and saturates.
  - mem_timeout sets when wait_cnt==MEM_TIMEOUT while mem_wait=1.
  - mem_timeout clears only on reset.
  - The hold continues regardless of timeout; the block does not abort the access.
- stall_count increments in every cycle where stall_front=1. flush_count increments in every cycle where flush_front=1. Both saturate at all-ones and do not wrap.

## Timing
- Control outputs are combinational, with zero-cycle latency from inputs. The pipeline registers sample them at the same clock edge.
- A load-use hazard produces exactly one bubble cycle. On the next cycle the load has moved to MEM and mem_read_idex=0, so no repeat occurs.
- A memory wait of N cycles with dmem_ready low asserts hold_back and stall_front for exactly N cycles.
- State, wait_cnt, the counters and mem_timeout update at the clock edge. Their values are visible the cycle after the event.
- Reset, asynchronous assertion:
  - stall_front, bubble_idex, flush_front and hold_back are forced to 0 while reset_n=0.
  - mem_timeout=0, stall_count=0, flush_count=0, state=RUN, wait_cnt=0.
- Reset asserted mid-wait clears the state immediately. After release, behaviour is driven solely by the current inputs.
- Simultaneous cases:
  - load_use + branch_taken_ex: flush only, no bubble.
  - mem_wait + load_use: hold only, and the bubble is deferred to the release cycle.
  - mem_wait + branch: hold only.

## Test plan
- Load x5 in EX, ID reads rs1=5 → stall_front=1 and bubble_idex=1 for 1 cycle; stall_count goes 0→1.
- rd_idex=0 with a load, or use_rs2_id=0 with rs2 matching → no stall.
- Branch taken while a load-use hazard exists → flush_front=1, bubble_idex=0, stall_front=0; flush_count goes to 1.
- dmem_req=1, dmem_ready=0 for 3 cycles then 1, with branch_taken_ex held high → hold_back=1 for 3 cycles, then flush_front=1 in the release cycle.
- MEM_TIMEOUT=4, wait of 10 cycles → mem_timeout rises after the 4th WAIT cycle and stays high after release until reset_n pulses low.
- CNT_W=4 with 20 load-use stalls → stall_count saturates at 15. reset_n low mid-wait → all outputs 0 asynchronously.
